// File: rtl/mrd_pkg.sv
// Shared definitions for the Richardson detector: default widths, FSM states
// and the saturation helper used when writing back x elements.
package mrd_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int XW_DEF       = 16;
    localparam int FRAC_DEF     = 8;
    localparam int MU_SHIFT_DEF = 6;
    localparam int ITER_DEF     = 4;
    localparam int NROW         = 16;
    localparam int ACCW         = WIDTH_DEF + XW_DEF + 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Clamp a wide signed value into the signed range of an xw-bit word.
    function automatic logic signed [63:0] sat_XW(input logic signed [63:0] v, input int xw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (xw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (xw - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/row_resid.sv
// Combinational residual of one row: r = (b[i] << FRAC) - sum_j A[i][j]*x[j].
// Kept independent of the sweep order so a Gauss-Seidel variant can reuse it.
module row_resid
    import mrd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int XW    = XW_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int AW    = ACCW
) (
    input  logic [NROW*WIDTH-1:0] a_row,
    input  logic [WIDTH-1:0]      b_i,
    input  logic [NROW*XW-1:0]    x_vec,
    output logic signed [AW-1:0]  r
);

    logic signed [AW-1:0] prod [NROW];
    logic signed [AW-1:0] t8 [8];
    logic signed [AW-1:0] t4 [4];
    logic signed [AW-1:0] t2 [2];
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] b_ext;

    // Products are formed at full accumulator width so the balanced tree never overflows.
    always_comb begin
        for (int j = 0; j < NROW; j++) begin
            prod[j] = AW'($signed(a_row[j*WIDTH +: WIDTH])) * AW'($signed(x_vec[j*XW +: XW]));
        end
        for (int k = 0; k < 8; k++) begin
            t8[k] = prod[2*k] + prod[2*k+1];
        end
        for (int k = 0; k < 4; k++) begin
            t4[k] = t8[2*k] + t8[2*k+1];
        end
        for (int k = 0; k < 2; k++) begin
            t2[k] = t4[2*k] + t4[2*k+1];
        end
        sum   = t2[0] + t2[1];
        b_ext = AW'($signed(b_i));
        r     = (b_ext <<< FRAC) - sum;
    end

endmodule

// File: rtl/richardson_detect.sv
// Fixed-count Jacobi/Richardson solver for A*x = b, one matrix row per cycle,
// delivering a 16-element Q.FRAC soft estimate with a one-cycle x_valid pulse.
module richardson_detect
    import mrd_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int XW       = XW_DEF,
    parameter int FRAC     = FRAC_DEF,
    parameter int MU_SHIFT = MU_SHIFT_DEF,
    parameter int ITER     = ITER_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NROW*WIDTH-1:0] A1,
    input  logic [NROW*WIDTH-1:0] A2,
    input  logic [NROW*WIDTH-1:0] A3,
    input  logic [NROW*WIDTH-1:0] A4,
    input  logic [NROW*WIDTH-1:0] A5,
    input  logic [NROW*WIDTH-1:0] A6,
    input  logic [NROW*WIDTH-1:0] A7,
    input  logic [NROW*WIDTH-1:0] A8,
    input  logic [NROW*WIDTH-1:0] A9,
    input  logic [NROW*WIDTH-1:0] A10,
    input  logic [NROW*WIDTH-1:0] A11,
    input  logic [NROW*WIDTH-1:0] A12,
    input  logic [NROW*WIDTH-1:0] A13,
    input  logic [NROW*WIDTH-1:0] A14,
    input  logic [NROW*WIDTH-1:0] A15,
    input  logic [NROW*WIDTH-1:0] A16,
    input  logic [NROW*WIDTH-1:0] y_in,
    output logic                  busy,
    output logic                  x_valid,
    output logic [NROW*XW-1:0]    x_out
);

    localparam int AW = WIDTH + XW + 5;
    localparam int RW = NROW * WIDTH;
    localparam int VW = NROW * XW;

    state_t state_q, state_d;
    logic [3:0] row_q, row_d;
    logic [3:0] it_q, it_d;
    logic [RW-1:0] a_q [NROW];
    logic [RW-1:0] a_d [NROW];
    logic [RW-1:0] b_q, b_d;
    logic [VW-1:0] x_q, x_d;
    logic [VW-1:0] x_next_q, x_next_d;
    logic [VW-1:0] x_out_q, x_out_d;

    logic signed [AW-1:0] r;
    logic signed [XW-1:0] x_i;
    logic signed [XW-1:0] x_upd;
    logic [VW-1:0] x_merged;
    logic last_row;
    logic last_sweep;

    row_resid #(
        .WIDTH (WIDTH),
        .XW    (XW),
        .FRAC  (FRAC),
        .AW    (AW)
    ) u_row_resid (
        .a_row (a_q[row_q]),
        .b_i   (b_q[row_q*WIDTH +: WIDTH]),
        .x_vec (x_q),
        .r     (r)
    );

    // x_merged is x_next with the current row's update folded in, so the
    // end-of-sweep copy includes row 15 without waiting an extra cycle.
    always_comb begin
        x_i      = $signed(x_q[row_q*XW +: XW]);
        x_upd    = XW'(sat_XW(64'(x_i) + 64'(r >>> MU_SHIFT), XW));
        x_merged = x_next_q;
        x_merged[row_q*XW +: XW] = x_upd;
    end

    assign last_row   = (row_q == 4'd15);
    assign last_sweep = (it_q == 4'(ITER - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_row && last_sweep) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NROW; i++) begin
                a_q[i] <= '0;
            end
            b_q      <= '0;
            x_q      <= '0;
            x_next_q <= '0;
            x_out_q  <= '0;
            row_q    <= '0;
            it_q     <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            x_q      <= x_d;
            x_next_q <= x_next_d;
            x_out_q  <= x_out_d;
            row_q    <= row_d;
            it_q     <= it_d;
        end
    end

    // x_out is loaded on the edge entering DONE so it is already current while x_valid is high.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        x_d      = x_q;
        x_next_d = x_next_q;
        x_out_d  = x_out_q;
        row_d    = row_q;
        it_d     = it_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d[0]   = A1;
                    a_d[1]   = A2;
                    a_d[2]   = A3;
                    a_d[3]   = A4;
                    a_d[4]   = A5;
                    a_d[5]   = A6;
                    a_d[6]   = A7;
                    a_d[7]   = A8;
                    a_d[8]   = A9;
                    a_d[9]   = A10;
                    a_d[10]  = A11;
                    a_d[11]  = A12;
                    a_d[12]  = A13;
                    a_d[13]  = A14;
                    a_d[14]  = A15;
                    a_d[15]  = A16;
                    b_d      = y_in;
                    x_d      = '0;
                    x_next_d = '0;
                    row_d    = '0;
                    it_d     = '0;
                end
            end
            RUN: begin
                x_next_d = x_merged;
                if (last_row) begin
                    x_d   = x_merged;
                    row_d = '0;
                    it_d  = it_q + 4'd1;
                    if (last_sweep) begin
                        x_out_d = x_merged;
                        it_d    = '0;
                    end
                end else begin
                    row_d = row_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy    = (state_q == RUN);
        x_valid = (state_q == DONE);
        x_out   = x_out_q;
    end

endmodule
